// File: rtl/led_pulse_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : led_pulse_scheduler
//  Description : Shares one LED between N_REQ pulse requesters. Each
//                single-cycle request is latched as pending. Pending
//                requests are served round-robin. Each served request
//                produces one fixed-length LED pulse followed by a fixed
//                dark gap.
//  Ports       : clk_i      - clock, all logic on the rising edge
//                rst_i      - synchronous active-high reset
//                req_i      - per-requester one-cycle request pulses
//                clear_i    - discard every pending request
//                led_o      - shared LED drive (registered)
//                grant_o    - one-hot owner of the current pulse, 0 outside ON
//                pending_o  - latched pending request bits
//                busy_o     - high whenever the scheduler is not IDLE
//                drop_o     - one-cycle flag: request hit an already-set
//                             pending bit
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pulse_scheduler #(
  parameter int N_REQ        = 4,
  parameter int PULSE_CYCLES = 8,
  parameter int GAP_CYCLES   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             clear_i,
  output logic             led_o,
  output logic [N_REQ-1:0] grant_o,
  output logic [N_REQ-1:0] pending_o,
  output logic             busy_o,
  output logic             drop_o
);

  localparam int c_MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);
  localparam int c_PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // The counter is loaded with (length - 1) on entry so that the entering
  // edge already counts as the first cycle of the phase.
  localparam logic [c_CNT_W-1:0] c_ON_LOAD  = c_CNT_W'(PULSE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LOAD = c_CNT_W'(GAP_CYCLES - 1);
  localparam logic [c_PTR_W-1:0] c_PTR_INIT = c_PTR_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0]   c_ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_PTR_W-1:0]   r_ptr;
  logic [N_REQ-1:0]     r_pend;
  logic                 r_led;
  logic [N_REQ-1:0]     r_grant;
  logic                 r_drop;

  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic [c_PTR_W-1:0]   w_ptr_nxt;
  logic                 w_led_nxt;
  logic [N_REQ-1:0]     w_grant_nxt;
  logic [N_REQ-1:0]     w_serve;
  logic [N_REQ-1:0]     w_keep;
  logic [N_REQ-1:0]     w_pend_nxt;
  logic                 w_drop_nxt;

  logic                 w_win_found;
  logic [c_PTR_W-1:0]   w_win_idx;
  logic [N_REQ-1:0]     w_win_mask;
  int                   w_idx_int;
  logic [c_PTR_W-1:0]   w_idx;

  // Round-robin search starting just after the last winner, on the
  // registered pending bits only.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = r_ptr;
    w_idx_int   = 0;
    w_idx       = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_idx_int = int'(r_ptr) + i;
      if (w_idx_int >= N_REQ) begin
        w_idx_int = w_idx_int - N_REQ;
      end
      w_idx = c_PTR_W'(w_idx_int);
      if (!w_win_found && r_pend[w_idx]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_idx;
      end
    end
    w_win_mask = c_ONE << w_win_idx;
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_led_nxt   = r_led;
    w_grant_nxt = r_grant;
    w_serve     = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_state_nxt = S_ON;
          w_cnt_nxt   = c_ON_LOAD;
          w_ptr_nxt   = w_win_idx;
          w_led_nxt   = 1'b1;
          w_grant_nxt = w_win_mask;
          w_serve     = w_win_mask;
        end
      end
      S_ON: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = c_GAP_LOAD;
          w_led_nxt   = 1'b0;
          w_grant_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_W'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          if (w_win_found) begin
            // Back-to-back service: no IDLE bubble between events.
            w_state_nxt = S_ON;
            w_cnt_nxt   = c_ON_LOAD;
            w_ptr_nxt   = w_win_idx;
            w_led_nxt   = 1'b1;
            w_grant_nxt = w_win_mask;
            w_serve     = w_win_mask;
          end else begin
            w_state_nxt = S_IDLE;
            w_led_nxt   = 1'b0;
            w_grant_nxt = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_led_nxt   = 1'b0;
        w_grant_nxt = '0;
      end
    endcase
  end

  // A request arriving in the cycle its bit is served or cleared survives,
  // because req_i is OR-ed in after the masking.
  always_comb begin
    w_keep     = ~w_serve & ~{N_REQ{clear_i}};
    w_pend_nxt = (r_pend & w_keep) | req_i;
    w_drop_nxt = |(req_i & r_pend & w_keep);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= c_PTR_INIT;
      r_pend  <= '0;
      r_led   <= 1'b0;
      r_grant <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_pend  <= w_pend_nxt;
      r_led   <= w_led_nxt;
      r_grant <= w_grant_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  assign led_o     = r_led;
  assign grant_o   = r_grant;
  assign pending_o = r_pend;
  assign busy_o    = (r_state != S_IDLE);
  assign drop_o    = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_led_pulse_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pulse_scheduler
//  Description : Self-checking bench for led_pulse_scheduler (N_REQ=4,
//                PULSE_CYCLES=8, GAP_CYCLES=4). Table vectors, directed
//                corner sequences and random traffic against a timeline
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pulse_scheduler;

  localparam int N = 4;
  localparam int P = 8;
  localparam int G = 4;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         clear_i = 1'b0;
  logic [N-1:0] req_i = '0;
  logic         led_o;
  logic [N-1:0] grant_o;
  logic [N-1:0] pending_o;
  logic         busy_o;
  logic         drop_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_pulse_scheduler #(
    .N_REQ       (N),
    .PULSE_CYCLES(P),
    .GAP_CYCLES  (G)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .clear_i  (clear_i),
    .led_o    (led_o),
    .grant_o  (grant_o),
    .pending_o(pending_o),
    .busy_o   (busy_o),
    .drop_o   (drop_o)
  );

  // Reference model: a pulse "slot" lasts P+G cycles measured from the edge
  // that granted it; m_t is the position inside the current slot.
  logic [N-1:0] m_pend;
  bit           m_active;
  int           m_t;
  int           m_owner;
  int           m_ptr;
  logic         m_drop;

  always @(posedge clk) begin
    logic [N-1:0] served;
    logic [N-1:0] keep;
    int           win;
    int           c;
    served = '0;
    win    = -1;
    if (rst_i) begin
      m_pend   = '0;
      m_active = 0;
      m_t      = 0;
      m_owner  = 0;
      m_ptr    = N - 1;
      m_drop   = 1'b0;
    end else begin
      if (!m_active || m_t == P + G - 1) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_ptr + k) % N;
          if (win < 0 && m_pend[c]) win = c;
        end
        if (win >= 0) begin
          m_active    = 1;
          m_t         = 0;
          m_owner     = win;
          m_ptr       = win;
          served[win] = 1'b1;
        end else begin
          m_active = 0;
        end
      end else begin
        m_t = m_t + 1;
      end
      keep   = clear_i ? '0 : ~served;
      m_drop = |(req_i & m_pend & keep);
      m_pend = (m_pend & keep) | req_i;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic led, input logic [N-1:0] gr,
                            input logic [N-1:0] pd, input logic bs, input logic dr);
    check({tag, " led"},     led_o,     led);
    check({tag, " grant"},   grant_o,   gr);
    check({tag, " pending"}, pending_o, pd);
    check({tag, " busy"},    busy_o,    bs);
    check({tag, " drop"},    drop_o,    dr);
  endtask

  // Drive inputs on the falling edge, observe 1 time unit after the rise.
  task automatic tick(input logic [N-1:0] r, input logic c, input logic rs);
    @(negedge clk);
    req_i   = r;
    clear_i = c;
    rst_i   = rs;
    @(posedge clk);
    #1;
    req_i   = '0;
    clear_i = 1'b0;
    rst_i   = 1'b0;
  endtask

  task automatic do_reset();
    tick('0, 1'b0, 1'b1);
    tick('0, 1'b0, 1'b1);
  endtask

  task automatic next_grant(input string nm, input logic [N-1:0] exp);
    int n;
    n = 0;
    while (grant_o != '0 && n < 60) begin tick('0, 1'b0, 1'b0); n++; end
    while (grant_o == '0 && n < 60) begin tick('0, 1'b0, 1'b0); n++; end
    if (n >= 60) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout waiting for grant, required %0h", nm, exp);
    end else begin
      check(nm, grant_o, exp);
    end
  endtask

  task automatic wait_idle(input string nm, output int ngr);
    int           n;
    logic [N-1:0] prev;
    n    = 0;
    ngr  = 0;
    prev = grant_o;
    while (busy_o && n < 100) begin
      tick('0, 1'b0, 1'b0);
      n++;
      if (grant_o != '0 && prev == '0) ngr++;
      prev = grant_o;
    end
    check({nm, " reaches idle"}, busy_o, 1'b0);
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         clr;
    logic         led;
    logic [N-1:0] grant;
    logic [N-1:0] pend;
    logic         busy;
    logic         drop;
  } vec_t;

  vec_t tbl1[$];
  vec_t tbl2[$];

  initial begin
    vec_t         v;
    int           ng;
    int           slot;
    int           t;
    logic [N-1:0] r;
    logic [3:0]   all_ones;

    // ---- Vector tables, built from the timing rules ----
    // Single request from requester 2.
    v = '{req: 4'b0100, clr: 1'b0, led: 1'b0, grant: 4'b0000, pend: 4'b0100, busy: 1'b0, drop: 1'b0};
    tbl1.push_back(v);
    for (int k = 1; k <= 14; k++) begin
      v.req   = '0;
      v.clr   = 1'b0;
      v.led   = (k >= 1 && k <= P);
      v.grant = v.led ? 4'b0100 : 4'b0000;
      v.pend  = '0;
      v.busy  = (k <= P + G);
      v.drop  = 1'b0;
      tbl1.push_back(v);
    end

    // All four at once: slot s owned by requester s, every slot P+G long.
    all_ones = 4'b1111;
    v = '{req: 4'b1111, clr: 1'b0, led: 1'b0, grant: 4'b0000, pend: 4'b1111, busy: 1'b0, drop: 1'b0};
    tbl2.push_back(v);
    for (int k = 1; k <= 4 * (P + G) + 3; k++) begin
      slot    = (k - 1) / (P + G);
      t       = (k - 1) % (P + G);
      v.req   = '0;
      v.clr   = 1'b0;
      v.drop  = 1'b0;
      if (slot < 4) begin
        v.led   = (t < P);
        v.grant = v.led ? (4'b0001 << slot) : 4'b0000;
        v.pend  = all_ones << (slot + 1);
        v.busy  = 1'b1;
      end else begin
        v.led   = 1'b0;
        v.grant = '0;
        v.pend  = '0;
        v.busy  = 1'b0;
      end
      tbl2.push_back(v);
    end

    // ---- Reset state ----
    do_reset();
    check_outs("reset", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // ---- Table: single request ----
    foreach (tbl1[i]) begin
      tick(tbl1[i].req, tbl1[i].clr, 1'b0);
      check_outs($sformatf("single[%0d]", i), tbl1[i].led, tbl1[i].grant,
                 tbl1[i].pend, tbl1[i].busy, tbl1[i].drop);
    end

    // ---- Table: simultaneous requests ----
    do_reset();
    foreach (tbl2[i]) begin
      tick(tbl2[i].req, tbl2[i].clr, 1'b0);
      check_outs($sformatf("simul[%0d]", i), tbl2[i].led, tbl2[i].grant,
                 tbl2[i].pend, tbl2[i].busy, tbl2[i].drop);
    end

    // ---- Fairness: owner re-requests during its own pulse ----
    do_reset();
    tick(4'b0011, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
    check("fair first grant", grant_o, 4'b0001);
    tick(4'b0001, 1'b0, 1'b0);
    check("fair pending", pending_o, 4'b0011);
    next_grant("fair second grant", 4'b0010);
    next_grant("fair third grant", 4'b0001);
    wait_idle("fair", ng);
    check("fair extra grants", ng, 0);

    // ---- Drop: repeated request while another owner is served ----
    do_reset();
    tick(4'b0001, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
    check("drop owner", grant_o, 4'b0001);
    tick(4'b1000, 1'b0, 1'b0);
    check("drop first req flag", drop_o, 1'b0);
    check("drop first req pend", pending_o, 4'b1000);
    tick(4'b1000, 1'b0, 1'b0);
    check("drop second req flag", drop_o, 1'b1);
    tick('0, 1'b0, 1'b0);
    check("drop flag clears", drop_o, 1'b0);
    next_grant("drop req3 grant", 4'b1000);
    wait_idle("drop", ng);
    check("drop req3 pulses", ng, 0);

    // ---- Clear during ON: pulse keeps full length ----
    do_reset();
    tick(4'b0001, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);                       // ON cycle 1
    tick(4'b0110, 1'b0, 1'b0);                  // ON cycle 2
    check("clear pending set", pending_o, 4'b0110);
    tick('0, 1'b1, 1'b0);                       // ON cycle 3
    check("clear pending zero", pending_o, 4'b0000);
    check("clear led kept", led_o, 1'b1);
    for (int k = 4; k <= P; k++) begin
      tick('0, 1'b0, 1'b0);
      check($sformatf("clear on led c%0d", k), led_o, 1'b1);
      check($sformatf("clear on grant c%0d", k), grant_o, 4'b0001);
    end
    tick('0, 1'b0, 1'b0);
    check("clear gap led", led_o, 1'b0);
    check("clear gap grant", grant_o, 4'b0000);
    for (int k = 2; k <= G; k++) begin
      tick('0, 1'b0, 1'b0);
      check($sformatf("clear gap busy g%0d", k), busy_o, 1'b1);
    end
    tick('0, 1'b0, 1'b0);
    check("clear idle", busy_o, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick('0, 1'b0, 1'b0);
      check($sformatf("clear no grant %0d", k), grant_o, 4'b0000);
    end

    // ---- Reset mid-pulse ----
    do_reset();
    tick(4'b0001, 1'b0, 1'b0);
    tick(4'b1010, 1'b0, 1'b0);                  // ON cycle 1
    check("rst pend", pending_o, 4'b1010);
    tick('0, 1'b0, 1'b0);                       // ON cycle 2
    check("rst led before", led_o, 1'b1);
    tick('0, 1'b0, 1'b1);                       // reset at ON cycle 3
    check_outs("rst mid", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick(4'b1111, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
    check("rst then grant0", grant_o, 4'b0001);

    // ---- Random traffic against the reference model ----
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 9) == 0);
      tick(r, ($urandom_range(0, 59) == 0), ($urandom_range(0, 499) == 0));
      check("rnd led",     led_o,     (m_active && m_t < P));
      check("rnd grant",   grant_o,   (m_active && m_t < P) ? (4'b0001 << m_owner) : 4'b0000);
      check("rnd pending", pending_o, m_pend);
      check("rnd busy",    busy_o,    m_active);
      check("rnd drop",    drop_o,    m_drop);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
